rr_arbiter_4: RTL and testbench
===============================

RR_ARBITER_4 -- requirements
Module: rr_arbiter_4

Interface
REQ-001 SHALL have parameter: N, 32, width of every data word.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port: req_valid  input  4  per-requester valid; bit i belongs to requester i.
REQ-005 SHALL have port: req_ready  output  4  per-requester accept; one-hot or zero.
REQ-006 SHALL have ports: req_data_0..req_data_3  input  N  requester payloads.
REQ-007 SHALL have port: out_valid  output  1  shared-port valid.
REQ-008 SHALL have port: out_ready  input  1  shared-port ready from the downstream consumer.
REQ-009 SHALL have port: out_data  output  N  payload of the granted requester.
REQ-010 SHALL have port: grant_idx  output  2  index of the current or last granted requester.
REQ-011 SHALL have port: busy  output  1  high while in state GRANT.

Function
REQ-012 SHALL implement a two-state FSM: IDLE and GRANT.
REQ-013 In IDLE with any req_valid bit set, SHALL pick the first set bit searching upward (wrapping) from rr_ptr, latch it into grant_idx, and enter GRANT on the next edge.
REQ-014 In IDLE with req_valid == 0, SHALL stay in IDLE and hold grant_idx.
REQ-015 In GRANT, out_valid SHALL equal req_valid[grant_idx], and out_data SHALL equal req_data_<grant_idx> through a 4:1 select, combinationally.
REQ-016 req_ready[i] SHALL be out_ready AND (state == GRANT) AND (grant_idx == i); all other bits SHALL be 0.
REQ-017 A transfer completes on an edge where out_valid && out_ready; rr_ptr SHALL then become (grant_idx+1) mod 4 and the FSM SHALL return to IDLE.
REQ-018 Latency from req_valid rising in IDLE to out_valid SHALL be exactly 1 cycle; peak throughput SHALL be one transfer per 2 cycles.
REQ-019 Grant SHALL NOT change while in GRANT, regardless of other req_valid bits changing.
REQ-020 If req_valid[grant_idx] drops in GRANT without a handshake (abort), the block SHALL return to IDLE with rr_ptr unchanged.
REQ-021 rr_ptr wrap-around SHALL occur from 3 to 0; with all four requesters continuously valid, the grant order SHALL be 0,1,2,3,0,...
REQ-022 out_valid SHALL be 0 in IDLE, and out_data SHALL then be 0.

Reset
REQ-023 On rst high at a clock edge, regardless of state: state=IDLE, rr_ptr=0, grant_idx=0, busy=0, out_valid=0, req_ready=0, out_data=0.
REQ-024 Reset asserted mid-GRANT SHALL drop the grant with no transfer counted, and rr_ptr SHALL return to 0.

Configuration
REQ-025 With macro RR_ARB_GRANT_CNT_EN defined, the block SHALL add outputs grant_cnt_0..grant_cnt_3 (each 16 bits); each SHALL increment by 1 on every completed transfer of its requester, saturate at 16'hFFFF, and clear on rst.
REQ-026 Without RR_ARB_GRANT_CNT_EN, these ports and counters SHALL NOT exist, and behaviour SHALL otherwise be identical.

Structure
REQ-027 Package arb_pkg SHALL hold: the FSM state enum (IDLE, GRANT), ARB_NUM_REQ=4, and GRANT_CNT_W=16.
REQ-028 Sub-module rr_pick_4 (combinational; inputs req[3:0] and ptr[1:0]; outputs idx[1:0] and any) SHALL perform the winner search.
REQ-029 out_data SHALL be produced by instantiating the existing mux_4_1 with select = grant_idx, gated to 0 in IDLE.

Verification
REQ-030 Single requester: rst, then req_valid=4'b0100 with req_data_2=32'hDEADBEEF and out_ready=1 -> out_valid=1 one cycle later, out_data=32'hDEADBEEF, req_ready=4'b0100, rr_ptr=3 after the handshake.
REQ-031 All valid: req_valid=4'b1111 held with out_ready=1 -> grant_idx sequence 0,1,2,3,0 on successive transfers, one transfer every 2 cycles.
REQ-032 Backpressure: grant on requester 1, out_ready=0 for 5 cycles while req_valid toggles for bits 0, 2 and 3 -> grant_idx stays 1 and out_data stays stable; out_ready=1 then completes the transfer.
REQ-033 Abort: in GRANT on requester 3, drop req_valid[3] with no handshake -> next cycle IDLE, rr_ptr unchanged, out_valid=0.
REQ-034 Reset mid-operation: assert rst while in GRANT on requester 2 -> next edge all outputs are 0; subsequent req_valid=4'b1111 grants requester 0 first.
REQ-035 With RR_ARB_GRANT_CNT_EN: 70000 transfers from requester 0 -> grant_cnt_0 = 16'hFFFF and grant_cnt_1..3 = 0.

Source files
------------

// File: rtl/arb_pkg.sv
// arb_pkg: shared types and constants for the 4-way round-robin arbiter.
//   arb_state_e  - FSM state encoding (IDLE, GRANT)
//   ARB_NUM_REQ  - number of requesters
//   GRANT_CNT_W  - width of the optional per-requester grant counters
package arb_pkg;
  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} arb_state_e;
  localparam int ARB_NUM_REQ = 4;
  localparam int GRANT_CNT_W = 16;
endpackage

// File: rtl/mux_4_1.sv
// mux_4_1: plain 4:1 word select.
//   din - four W-bit inputs, din[i] is chosen when sel == i
//   sel - 2-bit select
//   dout - selected word
module mux_4_1 #(
  parameter int W = 32
) (
  input  logic [3:0][W-1:0] din,
  input  logic [1:0]        sel,
  output logic [W-1:0]      dout
);
  assign dout = din[sel];
endmodule

// File: rtl/rr_pick_4.sv
// rr_pick_4: combinational round-robin winner search.
//   req - request bits
//   ptr - highest-priority position; search goes ptr, ptr+1, ... wrapping
//   idx - first set bit found from ptr (0 when nothing is set)
//   any - at least one request bit is set
module rr_pick_4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [1:0] idx,
  output logic       any
);
  logic       found;
  logic [1:0] cand;

  always_comb begin
    idx   = 2'd0;
    found = 1'b0;
    cand  = ptr;
    any   = |req;
    for (int k = 0; k < 4; k++) begin
      // 2-bit add wraps 3 -> 0 for free
      cand = ptr + 2'(k);
      if (!found && req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/rr_arbiter_4.sv
// rr_arbiter_4: 4-requester round-robin arbiter onto one valid/ready port.
// A grant is latched in IDLE and held in GRANT until the granted requester
// either hands off (valid && ready) or drops its valid (abort).
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   req_valid/req_ready   - per-requester handshake (ready is one-hot or 0)
//   req_data_0..3         - requester payloads (N bits)
//   out_valid/out_ready   - shared downstream handshake
//   out_data              - granted payload, 0 while IDLE
//   grant_idx             - current or last granted requester
//   busy                  - high in GRANT
// Optional: define RR_ARB_GRANT_CNT_EN to add grant_cnt_0..3, saturating
// 16-bit counts of completed transfers per requester.
module rr_arbiter_4
  import arb_pkg::*;
#(
  parameter int N = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [3:0]             req_valid,
  output logic [3:0]             req_ready,
  input  logic [N-1:0]           req_data_0,
  input  logic [N-1:0]           req_data_1,
  input  logic [N-1:0]           req_data_2,
  input  logic [N-1:0]           req_data_3,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N-1:0]           out_data,
  output logic [1:0]             grant_idx,
  output logic                   busy
`ifdef RR_ARB_GRANT_CNT_EN
  ,
  output logic [GRANT_CNT_W-1:0] grant_cnt_0,
  output logic [GRANT_CNT_W-1:0] grant_cnt_1,
  output logic [GRANT_CNT_W-1:0] grant_cnt_2,
  output logic [GRANT_CNT_W-1:0] grant_cnt_3
`endif
);

  arb_state_e state_q, state_d;
  logic [1:0] rr_ptr_q, rr_ptr_d;
  logic [1:0] grant_idx_q, grant_idx_d;
  logic [1:0] pick_idx;
  logic       pick_any;
  logic       xfer;
  logic [N-1:0] mux_out;

  rr_pick_4 u_pick (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .idx (pick_idx),
    .any (pick_any)
  );

  mux_4_1 #(.W(N)) u_mux (
    .din  ({req_data_3, req_data_2, req_data_1, req_data_0}),
    .sel  (grant_idx_q),
    .dout (mux_out)
  );

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_idx_d = grant_idx_q;
    out_valid   = 1'b0;
    req_ready   = 4'b0;
    xfer        = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_idx_d = pick_idx;
          state_d     = GRANT;
        end
      end
      GRANT: begin
        out_valid = req_valid[grant_idx_q];
        // ready is offered to the grantee even if its valid just dropped
        req_ready[grant_idx_q] = out_ready;
        if (out_valid && out_ready) begin
          xfer     = 1'b1;
          rr_ptr_d = grant_idx_q + 2'd1;
          state_d  = IDLE;
        end else if (!out_valid) begin
          // abort: release without advancing the pointer
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= 2'd0;
      grant_idx_q <= 2'd0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_idx_q <= grant_idx_d;
    end
  end

  assign busy      = (state_q == GRANT);
  assign grant_idx = grant_idx_q;
  assign out_data  = busy ? mux_out : '0;

`ifdef RR_ARB_GRANT_CNT_EN
  logic [ARB_NUM_REQ-1:0][GRANT_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < ARB_NUM_REQ; i++) begin
      if (xfer && (grant_idx_q == 2'(i)) && (cnt_q[i] != '1))
        cnt_d[i] = cnt_q[i] + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign grant_cnt_0 = cnt_q[0];
  assign grant_cnt_1 = cnt_q[1];
  assign grant_cnt_2 = cnt_q[2];
  assign grant_cnt_3 = cnt_q[3];
`else
  logic unused_xfer;
  assign unused_xfer = xfer;
`endif

endmodule

// File: tb/tb_rr_arbiter_4.sv
// tb_rr_arbiter_4: directed scenarios plus randomized traffic checked against
// a behavioural round-robin model.
module tb_rr_arbiter_4;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] d0, d1, d2, d3;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  grant_idx;
  logic        busy;
`ifdef RR_ARB_GRANT_CNT_EN
  logic [15:0] gc0, gc1, gc2, gc3;
`endif

  int total = 0;
  int bad   = 0;

  // model: is a grant held, which requester, where the search starts
  bit       m_busy;
  int       m_idx;
  int       m_ptr;
  int       m_cnt [4];

  always #5 clk = ~clk;

  rr_arbiter_4 #(.N(32)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_data_0(d0), .req_data_1(d1), .req_data_2(d2), .req_data_3(d3),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .grant_idx(grant_idx), .busy(busy)
`ifdef RR_ARB_GRANT_CNT_EN
    , .grant_cnt_0(gc0), .grant_cnt_1(gc1), .grant_cnt_2(gc2), .grant_cnt_3(gc3)
`endif
  );

  function automatic logic [31:0] data_of(int i);
    case (i)
      0: return d0;
      1: return d1;
      2: return d2;
      default: return d3;
    endcase
  endfunction

  // Advance the model by one edge with the current inputs, then the DUT.
  task automatic step();
    bit found;
    if (rst) begin
      m_busy = 0; m_idx = 0; m_ptr = 0;
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    end else if (!m_busy) begin
      found = 0;
      for (int k = 0; k < 4; k++) begin
        if (!found && req_valid[(m_ptr + k) % 4]) begin
          m_idx = (m_ptr + k) % 4;
          found = 1;
        end
      end
      if (found) m_busy = 1;
    end else if (req_valid[m_idx] && out_ready) begin
      m_ptr  = (m_idx + 1) % 4;
      m_busy = 0;
      if (m_cnt[m_idx] < 65535) m_cnt[m_idx]++;
    end else if (!req_valid[m_idx]) begin
      m_busy = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1; req_valid = 0; out_ready = 0;
    step();
    rst = 0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1; req_valid = 4'hF; out_ready = 1;
    step();
    #1;
    total++;
    if ({busy, out_valid, req_ready, grant_idx, out_data} !== 40'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%h exp=0",
               {busy, out_valid, req_ready, grant_idx, out_data});
    end
    rst = 0; req_valid = 0; out_ready = 0;
    #1;
  endtask

  task automatic test_single();
    do_reset();
    req_valid = 4'b0100; d2 = 32'hDEADBEEF; out_ready = 1;
    #1;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL single_idle_ov got=%b exp=0", out_valid); end
    step();
    total++;
    if ({out_valid, out_data, req_ready, grant_idx} !== {1'b1, 32'hDEADBEEF, 4'b0100, 2'd2}) begin
      bad++;
      $display("FAIL single_grant ov=%b data=%h rdy=%b idx=%0d exp 1 deadbeef 0100 2",
               out_valid, out_data, req_ready, grant_idx);
    end
    step();
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL single_release busy=%b exp=0", busy); end
    // pointer should now be 3: with everyone asking, 3 wins
    req_valid = 4'b1111;
    step();
    total++;
    if (grant_idx !== 2'd3) begin bad++; $display("FAIL single_ptr3 idx=%0d exp=3", grant_idx); end
  endtask

  task automatic test_all_valid();
    int exp_seq [5] = '{0, 1, 2, 3, 0};
    do_reset();
    req_valid = 4'b1111; out_ready = 1;
    for (int t = 0; t < 5; t++) begin
      step();
      total++;
      if (grant_idx !== 2'(exp_seq[t]) || out_valid !== 1'b1) begin
        bad++;
        $display("FAIL all_valid_seq[%0d] idx=%0d ov=%b exp idx=%0d ov=1",
                 t, grant_idx, out_valid, exp_seq[t]);
      end
      step();
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL all_valid_gap[%0d] busy=%b exp=0", t, busy); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] v;
    do_reset();
    v = $urandom; d1 = v;
    req_valid = 4'b0010; out_ready = 0;
    step();
    for (int t = 0; t < 5; t++) begin
      req_valid = 4'($urandom) | 4'b0010;
      #1;
      total++;
      if ({grant_idx, out_valid, out_data, req_ready} !== {2'd1, 1'b1, v, 4'b0000}) begin
        bad++;
        $display("FAIL backpressure_hold[%0d] idx=%0d ov=%b data=%h rdy=%b exp 1 1 %h 0000",
                 t, grant_idx, out_valid, out_data, req_ready, v);
      end
      step();
    end
    out_ready = 1;
    #1;
    total++;
    if (req_ready !== 4'b0010) begin bad++; $display("FAIL backpressure_ready rdy=%b exp=0010", req_ready); end
    step();
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL backpressure_done busy=%b exp=0", busy); end
    req_valid = 4'b1111;
    step();
    total++;
    if (grant_idx !== 2'd2) begin bad++; $display("FAIL backpressure_next idx=%0d exp=2", grant_idx); end
  endtask

  task automatic test_abort();
    do_reset();
    req_valid = 4'b1000; out_ready = 0;
    step();
    total++;
    if (grant_idx !== 2'd3 || busy !== 1'b1) begin
      bad++; $display("FAIL abort_grant idx=%0d busy=%b exp 3 1", grant_idx, busy);
    end
    req_valid = 4'b0000;
    step();
    total++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      bad++; $display("FAIL abort_idle busy=%b ov=%b exp 0 0", busy, out_valid);
    end
    // pointer still 0
    req_valid = 4'b1111; out_ready = 1;
    step();
    total++;
    if (grant_idx !== 2'd0) begin bad++; $display("FAIL abort_ptr idx=%0d exp=0", grant_idx); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_valid = 4'b0100; d2 = 32'h12345678; out_ready = 0;
    step();
    rst = 1;
    step();
    total++;
    if ({busy, out_valid, req_ready, grant_idx, out_data} !== 40'd0) begin
      bad++;
      $display("FAIL reset_mid_outputs got=%h exp=0",
               {busy, out_valid, req_ready, grant_idx, out_data});
    end
    rst = 0; req_valid = 4'b1111; out_ready = 1;
    step();
    total++;
    if (grant_idx !== 2'd0) begin bad++; $display("FAIL reset_mid_first idx=%0d exp=0", grant_idx); end
  endtask

  task automatic test_random();
    logic [3:0]  e_rdy;
    logic        e_ov;
    logic [31:0] e_data;
    do_reset();
    for (int t = 0; t < 600; t++) begin
      rst       = ($urandom_range(0, 59) == 0);
      req_valid = 4'($urandom);
      out_ready = 1'($urandom);
      d0 = $urandom; d1 = $urandom; d2 = $urandom; d3 = $urandom;
      #1;
      e_ov   = m_busy ? req_valid[m_idx] : 1'b0;
      e_data = m_busy ? data_of(m_idx) : 32'd0;
      e_rdy  = (m_busy && out_ready) ? 4'(1 << m_idx) : 4'd0;
      total++;
      if ({busy, out_valid, req_ready, grant_idx, out_data} !==
          {m_busy, e_ov, e_rdy, 2'(m_idx), e_data}) begin
        bad++;
        $display("FAIL random[%0d] got b=%b ov=%b rdy=%b idx=%0d d=%h exp b=%b ov=%b rdy=%b idx=%0d d=%h",
                 t, busy, out_valid, req_ready, grant_idx, out_data,
                 m_busy, e_ov, e_rdy, m_idx, e_data);
      end
`ifdef RR_ARB_GRANT_CNT_EN
      total++;
      if ({gc0, gc1, gc2, gc3} !== {16'(m_cnt[0]), 16'(m_cnt[1]), 16'(m_cnt[2]), 16'(m_cnt[3])}) begin
        bad++;
        $display("FAIL random_cnt[%0d] got=%h %h %h %h exp=%0d %0d %0d %0d",
                 t, gc0, gc1, gc2, gc3, m_cnt[0], m_cnt[1], m_cnt[2], m_cnt[3]);
      end
`endif
      step();
    end
    rst = 0;
  endtask

`ifdef RR_ARB_GRANT_CNT_EN
  task automatic test_cnt_saturate();
    do_reset();
    req_valid = 4'b0001; out_ready = 1;
    for (int t = 0; t < 70000; t++) begin
      step();
      step();
    end
    #1;
    total++;
    if ({gc0, gc1, gc2, gc3} !== {16'hFFFF, 16'h0, 16'h0, 16'h0}) begin
      bad++;
      $display("FAIL cnt_saturate got=%h %h %h %h exp=ffff 0 0 0", gc0, gc1, gc2, gc3);
    end
  endtask
`endif

  initial begin
    rst = 1; req_valid = 0; out_ready = 0;
    d0 = 0; d1 = 0; d2 = 0; d3 = 0;
    m_busy = 0; m_idx = 0; m_ptr = 0;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    @(posedge clk); #1;
    test_reset();
    test_single();
    test_all_valid();
    test_backpressure();
    test_abort();
    test_reset_mid();
    test_random();
`ifdef RR_ARB_GRANT_CNT_EN
    test_cnt_saturate();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
